// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
// Holds the receiver state enum, parity encodings, legal prescales and the data width.
package uart_pkg;

  localparam int DATA_W_DEF = 8;

  // Parity encoding, identical to the transmitter's PAR_TYP.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter and mid-bit sample capture.
// Ports: CLK/RST, rx_i line, run_i count enable, presc_i clocks per bit;
// edge_cnt_o position in bit, bit_done_o last edge, sampled_bit_o bit value.
// UART_RX_MAJORITY_EN selects a 2-of-3 vote over three mid-bit samples.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               rx_i,
  input  logic               run_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic [PRESC_W-1:0] edge_cnt_o,
  output logic               bit_done_o,
  output logic               sampled_bit_o
);

  logic [PRESC_W-1:0] edge_cnt_q;
  logic [PRESC_W-1:0] edge_cnt_d;
  logic [PRESC_W-1:0] last_e;
  logic [PRESC_W-1:0] mid_e;

  assign last_e = presc_i - PRESC_W'(1);
  assign mid_e  = presc_i >> 1;

  always_comb begin
    edge_cnt_d = '0;
    if (run_i) begin
      if (edge_cnt_q == last_e) begin
        edge_cnt_d = '0;
      end else begin
        edge_cnt_d = edge_cnt_q + PRESC_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_cnt_q <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign edge_cnt_o = edge_cnt_q;
  assign bit_done_o = run_i && (edge_cnt_q == last_e);

`ifdef UART_RX_MAJORITY_EN
  logic s0_q;
  logic s1_q;
  logic s2_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      if (edge_cnt_q == mid_e - PRESC_W'(2)) s0_q <= rx_i;
      if (edge_cnt_q == mid_e - PRESC_W'(1)) s1_q <= rx_i;
      if (edge_cnt_q == mid_e) s2_q <= rx_i;
    end
  end

  assign sampled_bit_o = (s0_q & s1_q) |
                         (s0_q & s2_q) |
                         (s1_q & s2_q);
`else
  logic s1_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_q <= 1'b0;
    end else if (edge_cnt_q == mid_e - PRESC_W'(1)) begin
      s1_q <= rx_i;
    end
  end

  assign sampled_bit_o = s1_q;
`endif

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, 8N1 / 8E1 / 8O1 frames.
// Ports: CLK, RST (async high), RX_IN, PAR_EN, PAR_TYP, Prescale in;
// P_DATA last good byte, data_valid / par_err / stp_err one-cycle strobes.
// Optional macro UART_RX_MAJORITY_EN enables 3-sample majority voting.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  input  logic [PRESC_W-1:0] Prescale,
  output logic [DATA_W-1:0]  P_DATA,
  output logic               data_valid,
  output logic               par_err,
  output logic               stp_err
);

  localparam int BW = $clog2(DATA_W);

  uart_rx_state_e state_q, state_d;

  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]  pdata_q, pdata_d;
  logic               par_bad_q, par_bad_d;
  logic               par_en_q, par_en_d;
  logic               par_typ_q, par_typ_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               dv_q, dv_d;
  logic               pe_q, pe_d;
  logic               se_q, se_d;

  logic [PRESC_W-1:0] edge_cnt;
  logic               bit_done;
  logic               sbit;
  logic               start_det;
  logic               run;

  // The idle counter is always parked at 0, so the
  // detecting cycle is edge 0 of the start bit.
  assign start_det = (state_q == IDLE) && !RX_IN &&
                     (edge_cnt == '0);
  assign run       = (state_q != IDLE) || start_det;

  uart_rx_sampler #(
    .PRESC_W(PRESC_W)
  ) u_sampler (
    .CLK          (CLK),
    .RST          (RST),
    .rx_i         (RX_IN),
    .run_i        (run),
    .presc_i      (presc_q),
    .edge_cnt_o   (edge_cnt),
    .bit_done_o   (bit_done),
    .sampled_bit_o(sbit)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    pdata_d   = pdata_q;
    par_bad_d = par_bad_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    presc_d   = presc_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_det) begin
          state_d   = START;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          presc_d   = Prescale;
          par_bad_d = 1'b0;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = sbit ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d[bit_cnt_q] = sbit;
          if (bit_cnt_q == BW'(DATA_W - 1)) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          par_bad_d = sbit ^ (^shift_q) ^
                      (par_typ_q == PAR_ODD);
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          dv_d    = sbit && !par_bad_q;
          pe_d    = par_bad_q;
          se_d    = !sbit;
          if (sbit && !par_bad_q) pdata_d = shift_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      pdata_q   <= '0;
      par_bad_q <= 1'b0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      presc_q   <= PRESC_W'(PRESC_8);
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      pdata_q   <= pdata_d;
      par_bad_q <= par_bad_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      presc_q   <= presc_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
    end
  end

  assign P_DATA     = pdata_q;
  assign data_valid = dv_q;
  assign par_err    = pe_q;
  assign stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: frame-level reference model with per-cycle strobe checks.
// Directed cases from the test plan followed by randomized frames.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

`ifdef UART_RX_MAJORITY_EN
  localparam bit MAJ = 1'b1;
`else
  localparam bit MAJ = 1'b0;
`endif

  uart_rx dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .Prescale  (Prescale),
    .P_DATA    (P_DATA),
    .data_valid(data_valid),
    .par_err   (par_err),
    .stp_err   (stp_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int       cyc;
    bit       dv;
    bit       pe;
    bit       se;
    bit [7:0] data;
  } exp_t;

  exp_t     q[$];
  int       cyc = 0;
  int       checks = 0;
  int       errors = 0;
  bit [7:0] exp_pdata = 8'h00;
  int       n_dv = 0;
  int       n_pe = 0;
  int       n_se = 0;
  int       last_dv_cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d",
               nm, act, exp, cyc);
    end
  endtask

  // Compare process: strobes and P_DATA every cycle out of reset.
  always @(negedge CLK) begin : mon
    exp_t e;
    bit   edv, epe, ese;
    if (!RST) begin
      edv = 0;
      epe = 0;
      ese = 0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e   = q.pop_front();
        edv = e.dv;
        epe = e.pe;
        ese = e.se;
        if (e.dv) exp_pdata = e.data;
      end
      chk("data_valid", int'(data_valid), int'(edv));
      chk("par_err", int'(par_err), int'(epe));
      chk("stp_err", int'(stp_err), int'(ese));
      chk("P_DATA", int'(P_DATA), int'(exp_pdata));
      if (data_valid) begin
        n_dv++;
        last_dv_cyc = cyc;
      end
      if (par_err) n_pe++;
      if (stp_err) n_se++;
    end
  end

  task automatic drive(input bit v);
    @(posedge CLK);
    #1;
    RX_IN = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1);
  endtask

  // One frame: gbit/goff place a 1-cycle glitch on a data bit,
  // abort>=0 resets mid-way through that data bit.
  task automatic send_frame(
    input bit [7:0] d, input int p, input bit pen,
    input bit ptyp, input bit pok, input bit stopb,
    input int gbit, input int goff, input int abort,
    output int c_o);
    bit       bits[11];
    int       n;
    bit [7:0] rd;
    bit       pbit, pbad, v;
    exp_t     e;
    pbit = (^d) ^ ptyp ^ !pok;
    n = pen ? 11 : 10;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    if (pen) bits[9] = pbit;
    bits[n-1] = stopb;
    rd = d;
    if (!MAJ && gbit >= 0 && goff == p/2 - 1)
      rd[gbit] = ~rd[gbit];
    pbad = pen && (pbit != ((^rd) ^ ptyp));
    c_o = 0;
    for (int i = 0; i < n; i++) begin
      for (int o = 0; o < p; o++) begin
        v = bits[i];
        if (gbit >= 0 && i == gbit + 1 && o == goff) v = ~v;
        @(posedge CLK);
        #1;
        RX_IN = v;
        if (i == 0 && o == 0) begin
          Prescale = 6'(p);
          PAR_EN = pen;
          PAR_TYP = ptyp;
          c_o = cyc;
          if (abort < 0) begin
            e.cyc = cyc + p * n;
            e.dv = stopb && !pbad;
            e.pe = pbad;
            e.se = !stopb;
            e.data = rd;
            q.push_back(e);
          end
        end else if (i == 0 && o == 1) begin
          // Config is latched at start; wiggle it afterwards.
          PAR_EN = 1'($urandom);
          PAR_TYP = 1'($urandom);
          Prescale = 6'($urandom);
        end
        if (abort >= 0 && i == abort + 1 && o == p/2) begin
          RST = 1'b1;
          q.delete();
          exp_pdata = 8'h00;
          idle(3);
          @(posedge CLK);
          #1;
          RST = 1'b0;
          return;
        end
      end
    end
  endtask

  initial begin : main
    int c0, d0, p0, s0, p, g, off;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_P_DATA", int'(P_DATA), 0);
    chk("rst_data_valid", int'(data_valid), 0);
    chk("rst_par_err", int'(par_err), 0);
    chk("rst_stp_err", int'(stp_err), 0);
    RST = 1'b0;
    idle(4);

    // 0x78, P=8, even parity -> valid after 88 cycles.
    d0 = n_dv;
    send_frame(8'h78, 8, 1, 0, 1, 1, -1, 0, -1, c0);
    idle(3);
    chk("t1_P_DATA", int'(P_DATA), 'h78);
    chk("t1_latency", last_dv_cyc - c0, 88);
    chk("t1_dv_count", n_dv - d0, 1);

    // Back-to-back 0x7C (even) then 0x70 (odd), P=16.
    d0 = n_dv; p0 = n_pe; s0 = n_se;
    send_frame(8'h7C, 16, 1, 0, 1, 1, -1, 0, -1, c0);
    send_frame(8'h70, 16, 1, 1, 1, 1, -1, 0, -1, c0);
    idle(3);
    chk("t2_dv_count", n_dv - d0, 2);
    chk("t2_P_DATA", int'(P_DATA), 'h70);
    chk("t2_err_count", (n_pe - p0) + (n_se - s0), 0);

    // Parity error: 0x78 with parity bit 1.
    d0 = n_dv; p0 = n_pe;
    send_frame(8'h78, 8, 1, 0, 0, 1, -1, 0, -1, c0);
    idle(3);
    chk("t3_pe_count", n_pe - p0, 1);
    chk("t3_dv_count", n_dv - d0, 0);
    chk("t3_P_DATA", int'(P_DATA), 'h70);

    // Stop error: P=32, no parity, 0x60, stop bit 0.
    d0 = n_dv; s0 = n_se;
    send_frame(8'h60, 32, 0, 0, 1, 0, -1, 0, -1, c0);
    idle(3);
    chk("t4_se_count", n_se - s0, 1);
    chk("t4_dv_count", n_dv - d0, 0);

    // Start glitch: 2 cycles low, then idle.
    d0 = n_dv; p0 = n_pe; s0 = n_se;
    Prescale = 6'd8;
    drive(1'b0);
    drive(1'b0);
    idle(12);
    chk("t5_strobes", (n_dv - d0) + (n_pe - p0) + (n_se - s0), 0);

    // Middle-sample glitch on data bit 3 of 0x5A.
    send_frame(8'h5A, 8, 0, 0, 1, 1, 3, 3, -1, c0);
    idle(3);
    chk("t6_P_DATA", int'(P_DATA), MAJ ? 'h5A : 'h52);

    // Reset in middle of 5th data bit, then clean 0xA5.
    d0 = n_dv;
    send_frame(8'h3C, 8, 1, 0, 1, 1, -1, 0, 4, c0);
    chk("t7_rst_P_DATA", int'(P_DATA), 0);
    idle(4);
    chk("t7_aborted", n_dv - d0, 0);
    send_frame(8'hA5, 8, 1, 1, 1, 1, -1, 0, -1, c0);
    idle(3);
    chk("t7_dv_count", n_dv - d0, 1);
    chk("t7_P_DATA", int'(P_DATA), 'hA5);

    // Randomized frames with out-of-window glitches.
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 2))
        0: p = 8;
        1: p = 16;
        default: p = 32;
      endcase
      g = -1;
      off = 0;
      if ($urandom_range(0, 1) == 1) begin
        g = $urandom_range(0, 7);
        if ($urandom_range(0, 1) == 1)
          off = $urandom_range(0, p/2 - 3);
        else
          off = $urandom_range(p/2 + 1, p - 1);
      end
      send_frame(8'($urandom), p, 1'($urandom),
                 1'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 4) != 0, g, off, -1, c0);
      idle($urandom_range(0, 3));
    end
    idle(4);
    chk("pending_expectations", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver; the downstream partner of the team's `UART_TX`, consuming its `TX_OUT` line. It oversamples `RX_IN` by a runtime prescale and recovers frames of one start bit, 8 data bits LSB-first, an optional parity bit and one stop bit. Each good byte is presented on `P_DATA` with a one-cycle `data_valid` strobe. Parity and stop errors are flagged instead of strobed.

## Interface
- `DATA_W`, 8: data bits per frame.
- `PRESC_W`, 6: width of `Prescale`.
- `CLK`  in  1: oversampling clock; all state updates on its rising edge.
- `RST`  in  1: reset, asynchronous and active-high. It clears all state and outputs immediately.
- `RX_IN`  in  1: serial line; idles at 1.
- `PAR_EN`  in  1: 1 means a parity bit follows the data.
- `PAR_TYP`  in  1: 0 selects even parity, 1 selects odd. The same encoding is used by `UART_TX`.
- `Prescale`  in  `PRESC_W`: clocks per bit. Legal values are 8, 16 and 32; other values give undefined results.
- `P_DATA`  out  `DATA_W`: last good byte; held until the next good frame.
- `data_valid`  out  1: one-cycle strobe when `P_DATA` updates.
- `par_err`  out  1: one-cycle strobe when the parity bit mismatches.
- `stp_err`  out  1: one-cycle strobe when the stop bit is sampled as 0.

## Operation
- FSM states are `IDLE`, `START`, `DATA`, `PARITY` and `STOP`.
- **Counters**
  - `edge_cnt` counts 0..`Prescale`-1 within each bit.
  - `bit_cnt` counts 0..7 in `DATA`.
- **IDLE**
  - `RX_IN`=0 moves the FSM to `START`. The detecting cycle counts as `edge_cnt`=0, so the next cycle is 1.
  - `RX_IN`=1 keeps the FSM in `IDLE`.
- **Sampling**
  - Each bit is decided from the samples taken at `edge_cnt` = P/2-2, P/2-1 and P/2, where P is `Prescale` (see Configuration).
  - The decided value is used at `edge_cnt`=P-1.
- **START**
  - If the decided bit is 1, it is a glitch: return to `IDLE` with no strobes.
  - If it is 0, go to `DATA` at `edge_cnt`=P-1.
- **DATA**
  - At the end of each bit, shift the bit into the shift register at position `bit_cnt`.
  - After bit 7, go to `PARITY` if `PAR_EN`=1, otherwise to `STOP`.
- **PARITY**
  - Expected bit = XOR of the 8 data bits, inverted when `PAR_TYP`=1.
  - Store whether it mismatches, then go to `STOP`.
- **STOP** (at `edge_cnt`=P-1)
  - If stop=1 and there is no parity mismatch: load `P_DATA` and pulse `data_valid`.
  - If there is a parity mismatch: pulse `par_err`. `P_DATA` is unchanged.
  - If stop=0: pulse `stp_err`. If a parity mismatch also occurred, `par_err` pulses too.
  - In all cases return to `IDLE`.
- `PAR_EN`, `PAR_TYP` and `Prescale` are sampled on the `IDLE`→`START` transition and held for the rest of the frame.

## Timing
- **Reset values:** `P_DATA`=0, `data_valid`=0, `par_err`=0, `stp_err`=0, FSM=`IDLE`, counters=0.
- **Frame length:** 10·P cycles without parity, 11·P with parity, counted from the `IDLE` cycle that detects start.
- **Strobe latency:** all strobes assert in the cycle after the last `edge_cnt`=P-1 of the stop bit. They are registered outputs, high for exactly one cycle.
- **Back-to-back frames:** a start edge in the first `IDLE` cycle after `STOP` is accepted with no lost frame.
- **Reset mid-frame:** the frame in progress is discarded, no strobe is produced, and the FSM is in `IDLE` after `RST` falls.
- **Mid-frame `RX_IN` changes:** transitions outside the sample window have no effect.
- There is no handshake and no backpressure. The consumer must capture `P_DATA` while `data_valid`=1 or before the next good frame overwrites it.

## Configuration
- Macro: `UART_RX_MAJORITY_EN`.
- **Defined:** each bit value is the 2-of-3 majority of the three sample points.
- **Undefined:** each bit value is the single sample at `edge_cnt`=P/2-1. The other two sample registers are not built.
- Frame timing is identical either way.

## Structure
- Shared package `uart_pkg`:
  - `uart_rx_state_e` enum.
  - Parity encoding constants `PAR_EVEN`=0 and `PAR_ODD`=1.
  - Legal prescale constants 8, 16 and 32.
  - `DATA_W` default.
- Sub-module `uart_rx_sampler` contains `edge_cnt`, the sample capture and the majority logic. It outputs `edge_cnt`, `bit_done` and `sampled_bit`.
- The top level holds the FSM, `bit_cnt`, the shift register, the parity check and the output registers.

## Test plan
- Prescale=8, `PAR_EN`=1, `PAR_TYP`=0, serial frame for 0x78 with parity 0 → `data_valid` once, `P_DATA`=0x78, 88 cycles after the start edge.
- Prescale=16, even parity, 0x7C with parity 1, sent back-to-back with 0x70 (odd parity, parity 0) → two `data_valid` pulses, `P_DATA`=0x7C then 0x70, no errors.
- Prescale=8, even parity, 0x78 sent with parity 1 → `par_err` pulses once, `data_valid` stays 0, `P_DATA` keeps its previous value.
- Prescale=32, `PAR_EN`=0, 0x60 with stop bit 0 → `stp_err` pulses once, no `data_valid`.
- `RX_IN` low for 2 cycles then high, Prescale=8 → start rejected, FSM back in `IDLE`, no strobes. Repeat with a 1-cycle glitch on a data bit's middle sample: with `UART_RX_MAJORITY_EN` the byte is correct; without it the byte is corrupted.
- `RST` asserted in the middle of the 5th data bit, then a clean 0xA5 frame → no strobe for the aborted frame, then `data_valid` with `P_DATA`=0xA5.
